// File: rtl/playlist_ctrl.sv
// rtl/playlist_ctrl.sv - playlist sequencer for a song ROM / note player
//
// Purpose: drives song index, play enable and player reload strobe from
// one-cycle front-panel pulses and the player's song_done level.
// Supports N songs, next/prev, pause/resume and four playback modes.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-low reset
//   play_button  in   pulse: play / pause toggle
//   next         in   pulse: skip forward
//   prev         in   pulse: skip back
//   mode         in   00 stop-at-end, 01 loop-all, 10 repeat-one, 11 shuffle
//   song_done    in   level: current song finished
//   play         out  registered: player runs
//   song         out  registered current song index
//   reset_play   out  registered: player reloads song start
module playlist_ctrl #(
    parameter int         NUM_SONGS = 4,
    parameter int         SONG_W    = 2,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play_button,
    input  logic              next,
    input  logic              prev,
    input  logic [1:0]        mode,
    input  logic              song_done,
    output logic              play,
    output logic [SONG_W-1:0] song,
    output logic              reset_play
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_PLAY  = 2'd2;
    localparam logic [1:0] S_PAUSE = 2'd3;

    localparam logic [1:0] M_STOP   = 2'b00;
    localparam logic [1:0] M_LOOP   = 2'b01;
    localparam logic [1:0] M_REPEAT = 2'b10;
    localparam logic [1:0] M_SHUF   = 2'b11;

    // Divisor guarded so a single-song build never divides by zero;
    // with one song every pick collapses to 0 anyway.
    localparam int            SHUF_DIV = (NUM_SONGS > 1) ? NUM_SONGS - 1 : 1;
    localparam logic [7:0]    DIV8     = 8'(SHUF_DIV);
    localparam logic [9:0]    NS10     = 10'(NUM_SONGS);
    localparam logic [SONG_W:0] LAST   = (SONG_W + 1)'(NUM_SONGS - 1);

    logic [1:0]        state_q, state_d;
    logic [SONG_W-1:0] song_q, song_d;
    logic              play_q, play_d;
    logic              reset_play_q, reset_play_d;
    logic [7:0]        lfsr_q, lfsr_d;

    logic [SONG_W:0]   song_ext;
    logic              at_last;
    logic [SONG_W-1:0] song_fwd;
    logic [SONG_W-1:0] song_back;
    logic [7:0]        lfsr_rem;
    logic [9:0]        shuf_sum;
    logic [SONG_W-1:0] song_shuf;
    logic [SONG_W-1:0] song_skip;

    // Fibonacci LFSR, taps 8,6,5,4; a nonzero seed never reaches zero.
    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    assign song_ext  = {1'b0, song_q};
    assign at_last   = (song_ext == LAST);
    assign song_fwd  = at_last ? '0 : song_q + 1'b1;
    assign song_back = (song_q == '0) ? LAST[SONG_W-1:0] : song_q - 1'b1;

    // Offset of 1..NUM_SONGS-1 from the current song, so the pick can
    // never repeat the song that is playing.
    assign lfsr_rem  = lfsr_q % DIV8;
    assign shuf_sum  = 10'(song_q) + 10'd1 + 10'(lfsr_rem);
    assign song_shuf = SONG_W'(shuf_sum % NS10);

    assign song_skip = (mode == M_SHUF) ? song_shuf : song_fwd;

    always_comb begin
        state_d = state_q;
        song_d  = song_q;
        case (state_q)
            S_IDLE: begin
                if (next) begin
                    song_d  = song_skip;
                    state_d = S_LOAD;
                end else if (prev) begin
                    song_d  = song_back;
                    state_d = S_LOAD;
                end else if (play_button) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_PLAY;
            end
            S_PLAY: begin
                if (song_done) begin
                    case (mode)
                        M_STOP: begin
                            if (at_last) begin
                                song_d  = '0;
                                state_d = S_IDLE;
                            end else begin
                                song_d  = song_fwd;
                                state_d = S_LOAD;
                            end
                        end
                        M_LOOP: begin
                            song_d  = song_fwd;
                            state_d = S_LOAD;
                        end
                        M_REPEAT: begin
                            state_d = S_LOAD;
                        end
                        default: begin
                            song_d  = song_shuf;
                            state_d = S_LOAD;
                        end
                    endcase
                end else if (next) begin
                    song_d  = song_skip;
                    state_d = S_LOAD;
                end else if (prev) begin
                    song_d  = song_back;
                    state_d = S_LOAD;
                end else if (play_button) begin
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (next) begin
                    song_d  = song_skip;
                    state_d = S_LOAD;
                end else if (prev) begin
                    song_d  = song_back;
                    state_d = S_LOAD;
                end else if (play_button) begin
                    state_d = S_PLAY;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are a registered decode of the next state so they line up
    // with state_q after the edge.
    assign play_d       = (state_d == S_PLAY);
    assign reset_play_d = (state_d == S_IDLE) || (state_d == S_LOAD);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            song_q       <= '0;
            play_q       <= 1'b0;
            reset_play_q <= 1'b1;
            lfsr_q       <= LFSR_SEED;
        end else begin
            state_q      <= state_d;
            song_q       <= song_d;
            play_q       <= play_d;
            reset_play_q <= reset_play_d;
            lfsr_q       <= lfsr_d;
        end
    end

    assign play       = play_q;
    assign song       = song_q;
    assign reset_play = reset_play_q;

endmodule

// File: tb/tb_playlist_ctrl.sv
// tb/tb_playlist_ctrl.sv - self-checking bench for playlist_ctrl
module tb_playlist_ctrl;

    localparam int N = 4;

    logic       clk;
    logic       reset;
    logic       play_button, next, prev, song_done;
    logic [1:0] mode;
    logic       play, reset_play;
    logic [1:0] song;

    logic       pb1, nx1, pv1, sd1;
    logic [1:0] md1;
    logic       play1, reset_play1;
    logic [0:0] song1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       play;
        logic [1:0] song;
        logic       rp;
    } exp_t;
    exp_t sbq[$];

    // reference model state
    int         m_st;     // 0 idle, 1 load, 2 play, 3 pause
    int         m_song;
    logic [7:0] m_lfsr;

    playlist_ctrl #(.NUM_SONGS(4), .SONG_W(2), .LFSR_SEED(8'hA5)) dut (
        .clk(clk), .reset(reset), .play_button(play_button), .next(next),
        .prev(prev), .mode(mode), .song_done(song_done),
        .play(play), .song(song), .reset_play(reset_play)
    );

    playlist_ctrl #(.NUM_SONGS(1), .SONG_W(1), .LFSR_SEED(8'hA5)) dut1 (
        .clk(clk), .reset(reset), .play_button(pb1), .next(nx1),
        .prev(pv1), .mode(md1), .song_done(sd1),
        .play(play1), .song(song1), .reset_play(reset_play1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input int cur, input logic [7:0] l);
        int r;
        r = int'(l) % (N - 1);
        return (cur + 1 + r) % N;
    endfunction

    function automatic int skip_fwd(input int cur, input logic [1:0] md, input logic [7:0] l);
        if (md == 2'b11) return pick(cur, l);
        return (cur + 1) % N;
    endfunction

    function automatic int skip_back(input int cur);
        return (cur == 0) ? N - 1 : cur - 1;
    endfunction

    task automatic model_step(input logic rst, input logic pb, input logic nx,
                              input logic pv, input logic [1:0] md, input logic sd);
        int ns, sg;
        if (!rst) begin
            m_st = 0; m_song = 0; m_lfsr = 8'hA5;
            return;
        end
        ns = m_st; sg = m_song;
        case (m_st)
            0, 3: begin
                if (nx)      begin sg = skip_fwd(m_song, md, m_lfsr); ns = 1; end
                else if (pv) begin sg = skip_back(m_song); ns = 1; end
                else if (pb) ns = (m_st == 0) ? 1 : 2;
            end
            1: ns = 2;
            default: begin
                if (sd) begin
                    if (md == 2'b00) begin
                        if (m_song == N - 1) begin sg = 0; ns = 0; end
                        else begin sg = m_song + 1; ns = 1; end
                    end else if (md == 2'b01) begin sg = (m_song + 1) % N; ns = 1; end
                    else if (md == 2'b10) ns = 1;
                    else begin sg = pick(m_song, m_lfsr); ns = 1; end
                end
                else if (nx) begin sg = skip_fwd(m_song, md, m_lfsr); ns = 1; end
                else if (pv) begin sg = skip_back(m_song); ns = 1; end
                else if (pb) ns = 3;
            end
        endcase
        m_st = ns; m_song = sg;
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    endtask

    task automatic tick(input logic rst, input logic pb, input logic nx, input logic pv,
                        input logic [1:0] md, input logic sd, input string tag);
        exp_t e, o;
        reset = rst; play_button = pb; next = nx; prev = pv; mode = md; song_done = sd;
        model_step(rst, pb, nx, pv, md, sd);
        e.play = (m_st == 2);
        e.song = 2'(m_song);
        e.rp   = (m_st == 0) || (m_st == 1);
        sbq.push_back(e);
        @(posedge clk);
        #1;
        o = sbq.pop_front();
        check({tag, ".play"}, play, o.play);
        check({tag, ".song"}, song, o.song);
        check({tag, ".rp"}, reset_play, o.rp);
        play_button = 0; next = 0; prev = 0; song_done = 0;
        pb1 = 0; nx1 = 0; pv1 = 0; sd1 = 0;
    endtask

    task automatic idle(input logic [1:0] md, input string tag);
        tick(1, 0, 0, 0, md, 0, tag);
    endtask

    initial begin
        int last_song;
        logic [3:0] visited;
        reset = 0; play_button = 0; next = 0; prev = 0; mode = 0; song_done = 0;
        pb1 = 0; nx1 = 0; pv1 = 0; sd1 = 0; md1 = 2'b00;
        m_st = 0; m_song = 0; m_lfsr = 8'hA5;

        tick(0, 0, 0, 0, 0, 0, "rst0");
        tick(0, 0, 0, 0, 0, 0, "rst1");
        check("rst_play", play, 0);
        check("rst_song", song, 0);
        check("rst_rp", reset_play, 1);

        tick(1, 1, 0, 0, 0, 0, "pb_load");
        check("pb_load_rp", reset_play, 1);
        idle(0, "load_play");
        check("load_play_play", play, 1);

        for (int i = 0; i < 3; i++) begin
            tick(1, 0, 1, 0, 0, 0, "m00_next");
            idle(0, "m00_load");
        end
        check("m00_song3", song, 3);
        tick(1, 0, 0, 0, 0, 1, "m00_done");
        check("m00_end_song", song, 0);
        check("m00_end_play", play, 0);
        idle(0, "m00_idle");
        idle(0, "m00_idle2");

        tick(1, 1, 0, 0, 1, 0, "m01_pb");
        idle(1, "m01_load");
        tick(1, 0, 0, 1, 1, 0, "m01_prev_wrap");
        check("m01_prev_wrap_song", song, 3);
        idle(1, "m01_load2");
        tick(1, 0, 0, 0, 1, 1, "m01_done");
        check("m01_done_song", song, 0);
        idle(1, "m01_load3");
        check("m01_play", play, 1);

        tick(1, 0, 1, 0, 2, 0, "m10_next");  idle(2, "m10_l");
        tick(1, 0, 1, 0, 2, 0, "m10_next");  idle(2, "m10_l");
        tick(1, 0, 0, 0, 2, 1, "m10_done");
        check("m10_done_song", song, 2);
        check("m10_done_rp", reset_play, 1);
        idle(2, "m10_l");
        for (int i = 0; i < 3; i++) begin
            tick(1, 0, 0, 1, 2, 0, "m10_prev");
            idle(2, "m10_l");
        end
        check("m10_prev_wrap", song, 3);

        tick(1, 0, 0, 1, 2, 0, "p_prev"); idle(2, "p_l");
        tick(1, 0, 0, 1, 2, 0, "p_prev"); idle(2, "p_l");
        tick(1, 1, 0, 0, 2, 0, "p_pause");
        check("p_pause_play", play, 0);
        check("p_pause_rp", reset_play, 0);
        check("p_pause_song", song, 1);
        tick(1, 0, 0, 0, 2, 1, "p_done_ign");
        tick(1, 0, 0, 0, 0, 1, "p_done_ign2");
        tick(1, 1, 0, 0, 2, 0, "p_resume");
        check("p_resume_rp", reset_play, 0);
        check("p_resume_play", play, 1);
        tick(1, 1, 0, 0, 2, 0, "p_pause2");
        tick(1, 0, 1, 0, 2, 0, "p_next");
        idle(2, "p_next_l");
        check("p_next_song", song, 2);

        visited = 4'b0;
        visited[song] = 1'b1;
        for (int i = 0; i < 200; i++) begin
            last_song = int'(song);
            tick(1, 0, 1, 0, 3, 0, "shuf_next");
            check("shuf_norep", (int'(song) != last_song), 1);
            check("shuf_range", (song < 2'(N - 1)) || (song == 2'(N - 1)), 1);
            visited[song] = 1'b1;
            idle(3, "shuf_l");
        end
        check("shuf_visited", visited, 4'hF);

        last_song = int'(song);
        tick(1, 1, 1, 1, 2, 1, "prio_all");
        check("prio_song", song, 2'(last_song));
        idle(2, "prio_l");

        tick(1, 0, 1, 0, 1, 0, "rl_next");
        tick(0, 0, 0, 0, 1, 0, "rl_reset");
        check("rl_song", song, 0);
        check("rl_rp", reset_play, 1);
        idle(1, "rl_idle");
        tick(1, 1, 0, 0, 1, 0, "rp_pb"); idle(1, "rp_l");
        tick(1, 1, 0, 0, 1, 0, "rp_pause");
        tick(0, 0, 0, 0, 1, 0, "rp_reset");
        check("rp_play", play, 0);
        idle(1, "rp_idle");

        pb1 = 1; idle(0, "n1_a");
        idle(0, "n1_b");
        check("n1_play", play1, 1);
        nx1 = 1; idle(0, "n1_c");
        check("n1_next_song", song1, 0);
        check("n1_next_rp", reset_play1, 1);
        check("n1_next_play", play1, 0);
        idle(0, "n1_d");
        check("n1_replay", play1, 1);
        md1 = 2'b00; sd1 = 1; idle(0, "n1_e");
        check("n1_stop_play", play1, 0);
        check("n1_stop_rp", reset_play1, 1);
        idle(0, "n1_f");
        check("n1_idle_play", play1, 0);
        check("n1_idle_song", song1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/playlist_ctrl.md
Name: playlist_ctrl

Overview:
- Parametrised playlist controller that sequences a note/song player.
- Drives the song index, play enable and the player's reset/reload strobe from front-panel pulses and the player's song_done flag.
- Generalises the first-generation 4-song controller:
  - N songs.
  - Previous-track control.
  - Pause/resume.
  - Four playback modes: stop-at-end, loop-all, repeat-one, shuffle.
- Sits between the debounced button logic and the song ROM/note player.

Parameters:
- NUM_SONGS, 4, number of songs; legal range 1..256.
- SONG_W, 2, width of the song index; must satisfy 2^SONG_W >= NUM_SONGS.
- LFSR_SEED, 8'hA5, nonzero reset value of the 8-bit shuffle LFSR.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset; sampled on rising clk.
- play_button  in  1  one-cycle pulse, active high; play/pause toggle.
- next  in  1  one-cycle pulse, active high; skip forward.
- prev  in  1  one-cycle pulse, active high; skip back.
- mode  in  2  00 stop-at-end, 01 loop-all, 10 repeat-one, 11 shuffle; sampled only at decision edges.
- song_done  in  1  level from player; current song finished.
- play  out  1  registered; player runs when 1.
- song  out  SONG_W  registered current song index, 0..NUM_SONGS-1.
- reset_play  out  1  registered; player reloads song start when 1.

Behaviour:
- Reset: reset==0 at a rising edge forces state IDLE, play=0, song=0, reset_play=1, lfsr=LFSR_SEED. It overrides all inputs and is legal in any state, including mid-LOAD or mid-PAUSE.
- All outputs are registers; no combinational input-to-output path.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Advances every cycle when reset==1 and never reaches 0.
- States: IDLE, LOAD, PLAY, PAUSE.
- IDLE:
  - Outputs: play=0, reset_play=1.
  - play_button -> LOAD, song unchanged.
  - next/prev update song as in PLAY, then -> LOAD.
  - song_done is ignored.
- LOAD:
  - Exactly one cycle. Outputs: play=0, reset_play=1.
  - Unconditionally -> PLAY. Inputs arriving during LOAD are dropped.
- PLAY:
  - Outputs: play=1, reset_play=0.
  - Priority when several inputs are high in the same cycle: song_done > next > prev > play_button.
  - song_done, by mode:
    - 00: if song==NUM_SONGS-1 -> IDLE with song=0; else song+1 -> LOAD.
    - 01: song+1, wrapping to 0 -> LOAD.
    - 10: song unchanged -> LOAD.
    - 11: shuffle pick -> LOAD.
  - next: song+1 with wrap in modes 00/01/10; shuffle pick in mode 11 -> LOAD.
  - prev: song-1, wrapping 0 -> NUM_SONGS-1, in all modes -> LOAD.
  - play_button -> PAUSE.
- PAUSE:
  - Outputs: play=0, reset_play=0; song and player position are held.
  - play_button -> PLAY with no reload.
  - next/prev update song as in PLAY -> LOAD, so playback resumes.
  - song_done is ignored.
- Shuffle pick:
  - NUM_SONGS==1: pick is 0.
  - Otherwise: (song + 1 + (lfsr mod (NUM_SONGS-1))) mod NUM_SONGS. The pick never equals the current song.
- NUM_SONGS==1: next/prev/song_done leave song=0 and still pass through LOAD (replay). Stop-at-end mode goes to IDLE.
- Latency: a decision edge updates song and enters LOAD. play returns to 1 exactly 2 edges after the triggering input is sampled.
- Index arithmetic is done in SONG_W+1 bits before wrap; song is never >= NUM_SONGS.

Test Plan:
- NUM_SONGS=4, reset low 2 cycles, then high -> play=0, song=0, reset_play=1. play_button pulse -> next edge LOAD (reset_play=1), following edge play=1, reset_play=0.
- mode=00, song=3, PLAY, song_done=1 -> IDLE, song=0, play=0. Repeat with mode=01 -> song=0, LOAD, then play=1.
- mode=10, song=2, song_done -> song stays 2, one reset_play pulse. Then prev -> song=1. prev at song=0 -> song=3.
- PLAY song=1: play_button -> PAUSE (play=0, reset_play=0). song_done asserted during PAUSE -> no change. play_button -> PLAY with no reset_play pulse. next in PAUSE -> song=2, LOAD, PLAY.
- mode=11, 200 consecutive next pulses -> song never repeats back-to-back, always <4, all of 0..3 visited. next+prev+song_done in the same cycle -> song_done rule applied only.
- reset driven low during LOAD and during PAUSE -> next edge song=0, play=0, reset_play=1, state IDLE. NUM_SONGS=1 build: next -> song=0 with reload pulse.
